// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from a normal-mode (non-FWFT) synchronous FIFO
// and sends them as start + 8 data (LSB first) + optional even parity + stop.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int PARITY_EN    = 0,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_en,
  input  logic             fifo_empty,
  input  logic             fifo_valid,
  input  logic [7:0]       fifo_data,
  output logic             fifo_rd_en,
  output logic             tx_serial,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] frame_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(CLKS_PER_BIT - 1);

  state_t           state_reg, state_next;
  logic [7:0]       clk_cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic             parity_reg;
  logic             err_reg;
  logic [CNT_W-1:0] frame_count_reg;
  logic             cnt_last;
  logic             timed_state;

  assign cnt_last    = (clk_cnt_reg == CNT_LAST);
  assign timed_state = (state_reg == S_START) || (state_reg == S_DATA) ||
                       (state_reg == S_PARITY) || (state_reg == S_STOP);

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE:   if (tx_en && !fifo_empty) state_next = S_REQ;
      S_REQ:    state_next = S_WAIT;
      S_WAIT:   state_next = fifo_valid ? S_START : S_IDLE;
      S_START:  if (cnt_last) state_next = S_DATA;
      S_DATA:   if (cnt_last && bit_idx_reg == 3'd7)
                  state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (cnt_last) state_next = S_STOP;
      S_STOP:   if (cnt_last) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Line level is a pure decode of registered state, so reset drives it high at once.
  always_comb begin
    tx_serial = 1'b1;
    unique case (state_reg)
      S_START:  tx_serial = 1'b0;
      S_DATA:   tx_serial = shift_reg[bit_idx_reg];
      S_PARITY: tx_serial = parity_reg;
      default:  tx_serial = 1'b1;
    endcase
  end

  assign fifo_rd_en  = (state_reg == S_REQ);
  assign busy        = (state_reg != S_IDLE);
  assign done        = (state_reg == S_STOP) && cnt_last;
  assign err         = err_reg;
  assign frame_count = frame_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      clk_cnt_reg     <= 8'd0;
      bit_idx_reg     <= 3'd0;
      shift_reg       <= 8'd0;
      parity_reg      <= 1'b0;
      err_reg         <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      state_reg <= state_next;

      if (timed_state && !cnt_last)
        clk_cnt_reg <= clk_cnt_reg + 8'd1;
      else
        clk_cnt_reg <= 8'd0;

      // Index wraps 7 -> 0 naturally as DATA is left.
      if (state_reg == S_DATA) begin
        if (cnt_last)
          bit_idx_reg <= bit_idx_reg + 3'd1;
      end else begin
        bit_idx_reg <= 3'd0;
      end

      if (state_reg == S_WAIT) begin
        if (fifo_valid) begin
          shift_reg  <= fifo_data;
          parity_reg <= ^fifo_data;
        end else begin
          err_reg <= 1'b1;
        end
      end

      if (done)
        frame_count_reg <= frame_count_reg + CNT_W'(1);
    end
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer for the team's 8-bit synchronous FIFO, configured in NORMAL (non-FWFT) read mode.
- Pops one byte at a time using the FIFO's rd_en/empty/valid handshake and serialises it as an asynchronous UART frame: start bit, 8 data bits LSB first, optional even parity, stop bit.
- Sits between the FIFO's data_out side and the chip's serial TX pin.

Parameters:
- CLKS_PER_BIT, 8: clk cycles per serial bit; legal range 2..255.
- PARITY_EN, 0: 0 = no parity bit; 1 = one even-parity bit after D7.
- CNT_W, 16: width of frame_count.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_en  input  1  permits starting a new frame; sampled only in IDLE.
- fifo_empty  input  1  FIFO empty flag.
- fifo_valid  input  1  FIFO read-valid, high the cycle after an accepted rd_en.
- fifo_data  input  8  FIFO data_out.
- fifo_rd_en  output  1  FIFO read request, one-cycle pulse.
- tx_serial  output  1  serial line; idle level high.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on the final cycle of each stop bit.
- err  output  1  sticky; set when fifo_valid is missing after a read request.
- frame_count  output  CNT_W  number of completed frames, wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE; tx_serial = 1; fifo_rd_en = 0; busy = 0; done = 0; err = 0; frame_count = 0; bit and clock counters = 0.
  - A reset mid-frame forces the line high immediately. The partial frame is abandoned and is not counted.
- Outputs: all outputs are registered or decoded purely from state (Moore). There is no combinational path from any input to any output.
- FSM states: IDLE, REQ, WAIT, START, DATA, PARITY, STOP.
- IDLE:
  - tx_serial = 1.
  - If tx_en && !fifo_empty at a clock edge, go to REQ. Otherwise remain in IDLE.
- REQ:
  - fifo_rd_en = 1 for exactly this one cycle; tx_serial = 1.
  - Always go to WAIT.
- WAIT:
  - tx_serial = 1.
  - If fifo_valid = 1, latch fifo_data into the shift register, compute parity = XOR of the 8 bits, and go to START.
  - If fifo_valid = 0, set err, go to IDLE, and send no frame.
- START: tx_serial = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx_serial = shift register bit [index], each bit held for CLKS_PER_BIT cycles, LSB first.
  - After bit 7, go to PARITY if PARITY_EN = 1, else go to STOP.
- PARITY: tx_serial = even-parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - tx_serial = 1 for CLKS_PER_BIT cycles.
  - done = 1 on the last of those cycles, and frame_count increments on the same edge.
  - Then go to IDLE.
- Frame length:
  - From the first START cycle to the end of STOP: (10 + PARITY_EN) × CLKS_PER_BIT cycles.
  - Latency: the edge that samples IDLE with tx_en && !fifo_empty is followed by exactly 2 line-high cycles (REQ, WAIT) before tx_serial falls.
- Back-to-back frames: STOP → IDLE → REQ → WAIT gives exactly 3 extra high cycles between the end of one stop bit and the next start bit.
- tx_en:
  - Deasserting tx_en mid-frame has no effect; the frame always completes.
  - tx_en is ignored outside IDLE.
- FIFO reads:
  - fifo_rd_en is never asserted while fifo_empty is high at the IDLE decision point.
  - At most one read is outstanding at any time, so the block never causes FIFO underflow.
- Clock counter: counts 0..CLKS_PER_BIT−1 and resets on every state or bit change.
- frame_count wraps from 2^CNT_W−1 to 0 without any flag.

Test Plan:
1. CLKS_PER_BIT = 4, PARITY_EN = 0, FIFO holds 0xA5, tx_en = 1:
   - One fifo_rd_en pulse.
   - tx_serial falls 2 cycles after the REQ decision edge.
   - Line sequence, each value held 4 cycles: 0, 1,0,1,0,0,1,0,1, 1.
   - done pulses once; frame_count = 1; busy is high for 40 + 2 cycles.
2. FIFO holds 0x01, 0xFF, 0x3C with tx_en held high:
   - Three frames go out in order.
   - Exactly 3 high cycles separate each stop bit from the next start bit.
   - fifo_empty rises after the third read; the block then idles with busy = 0 and frame_count = 3.
3. PARITY_EN = 1, bytes 0x07 and 0x03:
   - Parity bits are 1 and 0 respectively.
   - Each frame is 44 cycles at CLKS_PER_BIT = 4.
4. tx_en high with fifo_empty = 1 for 50 cycles:
   - fifo_rd_en stays 0, tx_serial stays 1, busy stays 0.
   - tx_en dropped during DATA bit 3: the frame still completes and done pulses.
5. Reset mid-frame: rst_n driven low asynchronously (between edges) during DATA bit 4:
   - tx_serial = 1, busy = 0, frame_count unchanged at 0 immediately, before the next clock edge.
   - After release, the next byte transmits normally.
6. Forced fifo_valid = 0 in WAIT:
   - err = 1 and the block returns to IDLE with no start bit.
   - A subsequent good frame transmits normally while err remains 1 until reset.
